// File: rtl/emu_pkg.sv
// Shared types and widths for the emulation transactor: sequencer states and byte/counter widths.
package emu_pkg;
  localparam int BYTE_W = 8;
  localparam int STEP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_CAPT = 2'd3
  } emu_state_e;
endpackage

// File: rtl/emu_xactor_p_if.sv
// Host command / DUT vector bundle of the transactor. The master side is the host plus the DUT
// wrapper; the slave side is emu_xactor_p.
interface emu_xactor_p_if #(
  parameter int NUM_STIM = 2,
  parameter int NUM_OUT  = 4,
  parameter int ADDR_W   = 4
) ();
  import emu_pkg::*;

  logic [BYTE_W-1:0]          Din_emu;
  logic [BYTE_W-1:0]          Dout_emu;
  logic [ADDR_W-1:0]          Addr_emu;
  logic                       wr_emu;
  logic                       load_emu;
  logic                       get_emu;
  logic                       step_emu;
  logic [STEP_W-1:0]          step_cnt;
  logic [NUM_STIM*BYTE_W-1:0] stim_o;
  logic [NUM_OUT*BYTE_W-1:0]  vect_i;
  logic                       dut_ce;
  logic                       busy;

  modport master (
    output Din_emu, Addr_emu, wr_emu, load_emu, get_emu, step_emu, step_cnt, vect_i,
    input  Dout_emu, stim_o, dut_ce, busy
  );

  modport slave (
    input  Din_emu, Addr_emu, wr_emu, load_emu, get_emu, step_emu, step_cnt, vect_i,
    output Dout_emu, stim_o, dut_ce, busy
  );
endinterface

// File: rtl/emu_step_seq.sv
// Step sequencer: LOAD (1 cycle), RUN (dut_ce for i_cnt cycles), CAPT (1 cycle); busy for i_cnt+2 cycles.
// Starts are only taken in IDLE; the caller must qualify i_start with !o_busy.
module emu_step_seq
  import emu_pkg::*;
(
  input  logic              clk_emu,
  input  logic              rst_emu_n,
  input  logic              i_start,
  input  logic [STEP_W-1:0] i_cnt,
  output logic              o_dut_ce,
  output logic              o_busy,
  output logic              o_do_load,
  output logic              o_do_capt
);

  emu_state_e        r_state;
  logic [STEP_W-1:0] r_cnt;
  logic              r_dut_ce;
  logic              r_busy;
  logic              r_do_load;
  logic              r_do_capt;

  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dut_ce  <= 1'b0;
      r_busy    <= 1'b0;
      r_do_load <= 1'b0;
      r_do_capt <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_cnt     <= i_cnt;
            r_state   <= ST_LOAD;
            r_busy    <= 1'b1;
            r_do_load <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_do_load <= 1'b0;
          if (r_cnt == '0) begin
            r_state   <= ST_CAPT;
            r_do_capt <= 1'b1;
          end else begin
            r_state  <= ST_RUN;
            r_dut_ce <= 1'b1;
          end
        end
        ST_RUN: begin
          // r_cnt holds the pulses still owed including the current one
          if (r_cnt == STEP_W'(1)) begin
            r_cnt     <= '0;
            r_dut_ce  <= 1'b0;
            r_do_capt <= 1'b1;
            r_state   <= ST_CAPT;
          end else begin
            r_cnt <= r_cnt - STEP_W'(1);
          end
        end
        ST_CAPT: begin
          r_do_capt <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_dut_ce  = r_dut_ce;
  assign o_busy    = r_busy;
  assign o_do_load = r_do_load;
  assign o_do_capt = r_do_capt;

endmodule

// File: rtl/emu_xactor_p.sv
// Emulation transactor: host-written stimulus buffer -> stim_o, vect_i -> capture buffer -> Dout_emu.
// Host reads return one cycle after the address; commands other than wr_emu are dropped while busy.
module emu_xactor_p
  import emu_pkg::*;
#(
  parameter int NUM_STIM = 2,
  parameter int NUM_OUT  = 4,
  parameter int ADDR_W   = 4
) (
  input  logic           clk_emu,
  input  logic           rst_emu_n,
  emu_xactor_p_if.slave  bus
);

  logic [NUM_STIM-1:0][BYTE_W-1:0] r_stim_buf;
  logic [NUM_STIM-1:0][BYTE_W-1:0] r_stim;
  logic [NUM_OUT-1:0][BYTE_W-1:0]  r_cap;
  logic [BYTE_W-1:0]               r_dout;
  logic [BYTE_W-1:0]               w_rd_byte;
  logic w_busy, w_dut_ce, w_do_load, w_do_capt;
  logic w_load_acc, w_get_acc, w_step_acc, w_wr_acc;

  // Priority in IDLE: load > get > step > write; only writes survive while busy
  assign w_load_acc = !w_busy && bus.load_emu;
  assign w_get_acc  = !w_busy && !bus.load_emu && bus.get_emu;
  assign w_step_acc = !w_busy && !bus.load_emu && !bus.get_emu && bus.step_emu;
  assign w_wr_acc   = bus.wr_emu &&
                      (w_busy || !(bus.load_emu || bus.get_emu || bus.step_emu));

  emu_step_seq u_seq (
    .clk_emu   (clk_emu),
    .rst_emu_n (rst_emu_n),
    .i_start   (w_step_acc),
    .i_cnt     (bus.step_cnt),
    .o_dut_ce  (w_dut_ce),
    .o_busy    (w_busy),
    .o_do_load (w_do_load),
    .o_do_capt (w_do_capt)
  );

  // Exact address match per byte: out-of-range addresses hit nothing
  always_comb begin
    w_rd_byte = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (bus.Addr_emu == ADDR_W'(k)) w_rd_byte = r_cap[k];
    end
  end

  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      r_stim_buf <= '0;
      r_stim     <= '0;
      r_cap      <= '0;
      r_dout     <= '0;
    end else begin
      for (int k = 0; k < NUM_STIM; k++) begin
        if (w_wr_acc && bus.Addr_emu == ADDR_W'(k)) r_stim_buf[k] <= bus.Din_emu;
      end
      if (w_load_acc || w_do_load) r_stim <= r_stim_buf;
      if (w_get_acc || w_do_capt)  r_cap  <= bus.vect_i;
      // Reads see the old capture value in the capture cycle itself
      if (!(w_load_acc || w_get_acc)) r_dout <= w_rd_byte;
    end
  end

  assign bus.stim_o   = r_stim;
  assign bus.Dout_emu = r_dout;
  assign bus.dut_ce   = w_dut_ce;
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_emu_xactor_p.sv
// Randomized bench for emu_xactor_p against a command-level model of buffers and step timing.
module tb_emu_xactor_p;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  emu_xactor_p_if #(.NUM_STIM(2), .NUM_OUT(4), .ADDR_W(4)) bus ();

  emu_xactor_p #(.NUM_STIM(2), .NUM_OUT(4), .ADDR_W(4)) dut (
    .clk_emu   (clk),
    .rst_emu_n (rst_n),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  m_buf [2];
  logic [15:0] m_stim;
  logic [31:0] m_cap;
  logic [31:0] cur_vect;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input int a);
    if (a < 4) return m_cap[a*8 +: 8];
    return 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_buf[0] = 8'h00;
    m_buf[1] = 8'h00;
    m_stim   = 16'h0000;
    m_cap    = 32'h0;
  endtask

  task automatic host_wr(input int a, input logic [7:0] d);
    bus.Addr_emu = 4'(a);
    bus.Din_emu  = d;
    bus.wr_emu   = 1'b1;
    tick();
    bus.wr_emu   = 1'b0;
    if (a < 2) m_buf[a] = d;
  endtask

  task automatic host_load();
    bus.load_emu = 1'b1;
    tick();
    bus.load_emu = 1'b0;
    m_stim = {m_buf[1], m_buf[0]};
    chk("load_stim", bus.stim_o, m_stim);
    chk("load_busy", bus.busy, 1'b0);
  endtask

  task automatic host_get(input logic [31:0] v);
    bus.vect_i  = v;
    cur_vect    = v;
    bus.get_emu = 1'b1;
    tick();
    bus.get_emu = 1'b0;
    m_cap = v;
  endtask

  task automatic host_rd(input int a);
    bus.Addr_emu = 4'(a);
    tick();
    chk($sformatf("rd_a%0d", a), bus.Dout_emu, exp_rd(a));
  endtask

  task automatic do_step(input int n);
    int a = $urandom_range(0, 3);
    int busy_cyc = 0, ce_cyc = 0, ce_runs = 0, cyc = 0, wa;
    logic prev_ce = 1'b0;
    logic [15:0] snap = {m_buf[1], m_buf[0]};
    logic [7:0]  old_byte = exp_rd(a);
    bus.Addr_emu = 4'(a);
    bus.step_cnt = 8'(n);
    bus.step_emu = 1'b1;
    tick();
    bus.step_emu = 1'b0;
    bus.step_cnt = 8'($urandom);
    while (bus.busy === 1'b1 && cyc < 400) begin
      busy_cyc++;
      cyc++;
      bus.wr_emu = 1'b0; bus.load_emu = 1'b0; bus.get_emu = 1'b0; bus.step_emu = 1'b0;
      if (bus.dut_ce === 1'b1) begin
        ce_cyc++;
        if (!prev_ce) ce_runs++;
        cur_vect    = $urandom;
        bus.vect_i  = cur_vect;
        chk("run_stim_hold", bus.stim_o, snap);
        wa = $urandom_range(0, 3);
        bus.Addr_emu = 4'(wa);
        bus.Din_emu  = 8'($urandom);
        bus.wr_emu   = 1'($urandom_range(0, 1));
        if (bus.wr_emu && wa < 2) m_buf[wa] = bus.Din_emu;
        bus.load_emu = 1'($urandom_range(0, 1));
        bus.get_emu  = 1'($urandom_range(0, 1));
        bus.step_emu = 1'($urandom_range(0, 1));
      end else begin
        bus.Addr_emu = 4'(a);
      end
      prev_ce = bus.dut_ce;
      tick();
    end
    bus.wr_emu = 1'b0; bus.load_emu = 1'b0; bus.get_emu = 1'b0; bus.step_emu = 1'b0;
    chk($sformatf("step%0d_done", n), bus.busy, 1'b0);
    chk($sformatf("step%0d_busy_cyc", n), 64'(busy_cyc), 64'(n + 2));
    chk($sformatf("step%0d_ce_cyc", n), 64'(ce_cyc), 64'(n));
    chk($sformatf("step%0d_ce_runs", n), 64'(ce_runs), (n > 0) ? 64'd1 : 64'd0);
    chk($sformatf("step%0d_stim", n), bus.stim_o, snap);
    chk($sformatf("step%0d_rd_precapt", n), bus.Dout_emu, old_byte);
    m_stim = snap;
    m_cap  = cur_vect;
    tick();
    chk($sformatf("step%0d_rd_postcapt", n), bus.Dout_emu, exp_rd(a));
  endtask

  task automatic reset_mid_run();
    int ce_seen = 0, cyc = 0;
    bus.step_cnt = 8'd10;
    bus.step_emu = 1'b1;
    tick();
    bus.step_emu = 1'b0;
    while (ce_seen < 4 && cyc < 50) begin
      if (bus.dut_ce === 1'b1) ce_seen++;
      cyc++;
      if (ce_seen < 4) tick();
    end
    chk("rst_run_reached", 64'(ce_seen), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_async_ce", bus.dut_ce, 1'b0);
    chk("rst_async_busy", bus.busy, 1'b0);
    chk("rst_async_stim", bus.stim_o, 16'h0);
    chk("rst_async_dout", bus.Dout_emu, 8'h0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) host_rd(i);
    host_load();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.Din_emu = '0; bus.Addr_emu = '0; bus.wr_emu = 1'b0; bus.load_emu = 1'b0;
    bus.get_emu = 1'b0; bus.step_emu = 1'b0; bus.step_cnt = '0; bus.vect_i = '0;
    cur_vect = '0;
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_ce", bus.dut_ce, 1'b0);
    chk("reset_stim", bus.stim_o, 16'h0);
    chk("reset_dout", bus.Dout_emu, 8'h0);
    rst_n = 1'b1;

    host_wr(0, 8'hA5);
    host_wr(1, 8'h3C);
    host_load();
    chk("stim_3CA5", bus.stim_o, 16'h3CA5);

    host_get(32'hDEADBEEF);
    host_rd(0); host_rd(1); host_rd(2); host_rd(3); host_rd(5);
    chk("dout_DE_const", bus.Dout_emu, 8'h00);

    // load and get together: only the load acts
    host_wr(0, 8'h11);
    bus.vect_i   = 32'h12345678;
    bus.load_emu = 1'b1;
    bus.get_emu  = 1'b1;
    tick();
    bus.load_emu = 1'b0;
    bus.get_emu  = 1'b0;
    bus.vect_i   = cur_vect;
    m_stim = {m_buf[1], m_buf[0]};
    chk("loadget_stim", bus.stim_o, m_stim);
    for (int i = 0; i < 4; i++) host_rd(i);
    host_wr(2, 8'h77);
    host_wr(15, 8'h99);
    host_load();

    do_step(3);
    do_step(0);
    host_load();

    reset_mid_run();

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: host_wr($urandom_range(0, 15), 8'($urandom));
        1: host_load();
        2: host_get($urandom);
        3: host_rd($urandom_range(0, 15));
        default: do_step($urandom_range(0, 12));
      endcase
    end
    do_step(255);
    host_load();
    for (int i = 0; i < 6; i++) host_rd(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
